bcd_scan_ctrl: RTL and testbench

Controller for a 3-digit BCD counter with time-multiplexed digit output.
- Owns run/stop/clear/load sequencing.
- Generates the count tick from a prescaler.
- Schedules the single shared 4-bit digit bus across ones/tens/hundreds plus one blank slot, with coherent one-hot digit enables.
- Sits between front-panel control logic and the display driver.

---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_scan_ctrl_if.sv | 31 +++
 rtl/bcd_digit_inc.sv | 25 ++
 rtl/bcd_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the 3-digit BCD scan controller.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned NUM_DIGITS    = 3;
  localparam int unsigned BCD_MAX_DIGIT = 9;
  localparam int unsigned COUNT_W       = BCD_DIGIT_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    SLOT_ONES,
    SLOT_TENS,
    SLOT_HUNDREDS,
    SLOT_BLANK
  } slot_e;

  typedef enum logic {
    ST_STOPPED,
    ST_RUNNING
  } run_state_e;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t hundreds;
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_count_t;

  // Clamp a nibble into the legal BCD range.
  function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
    return (d > bcd_digit_t'(BCD_MAX_DIGIT)) ? bcd_digit_t'(BCD_MAX_DIGIT) : d;
  endfunction

endpackage

// File: rtl/bcd_scan_ctrl_if.sv
// Front-panel command / load handshake and display bus of bcd_scan_ctrl.
interface bcd_scan_ctrl_if;
  import bcd_pkg::*;

  logic               start;
  logic               stop;
  logic               clear;
  logic               load_valid;
  logic [COUNT_W-1:0] load_bcd;
  logic               load_ready;
  logic [BCD_DIGIT_W-1:0] q;
  logic               en_ones;
  logic               en_tens;
  logic               en_hundreds;
  logic [COUNT_W-1:0] count_bcd;
  logic               running;
  logic               wrap;

  // Front-panel side: issues commands, watches the display bus.
  modport master (
    output start, stop, clear, load_valid, load_bcd,
    input  load_ready, q, en_ones, en_tens, en_hundreds, count_bcd, running, wrap
  );

  // Controller side.
  modport slave (
    input  start, stop, clear, load_valid, load_bcd,
    output load_ready, q, en_ones, en_tens, en_hundreds, count_bcd, running, wrap
  );

endinterface

// File: rtl/bcd_digit_inc.sv
// Combinational single BCD digit increment with carry chain support.
module bcd_digit_inc
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       carry_in_i,
  output bcd_digit_t digit_next_o,
  output logic       carry_out_o
);

  // Add carry_in; 9 rolls to 0 and propagates the carry.
  always_comb begin
    digit_next_o = digit_i;
    carry_out_o  = 1'b0;
    if (carry_in_i) begin
      if (digit_i >= bcd_digit_t'(BCD_MAX_DIGIT)) begin
        digit_next_o = '0;
        carry_out_o  = 1'b1;
      end else begin
        digit_next_o = digit_i + bcd_digit_t'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// 3-digit BCD counter controller with run/stop/clear/load sequencing and a
// time-multiplexed digit bus (ones, tens, hundreds, blank).
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module bcd_scan_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  bcd_scan_ctrl_if.slave  bus
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  run_state_e           state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  bcd_count_t           count_q, count_d;
  logic                 wrap_q, wrap_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  slot_e                slot_q, slot_d;
  bcd_digit_t           q_q, q_d;
  logic [2:0]           en_q, en_d;   // {hundreds, tens, ones}

  logic       running_c;
  logic       load_ready_c;
  logic       load_fire;
  logic       tick;
  logic       show_tens;
  logic       show_hundreds;
  bcd_digit_t inc_ones, inc_tens, inc_hundreds;
  logic       carry_ones, carry_tens, carry_hundreds;

  assign load_fire = bus.load_valid && load_ready_c;
  assign tick      = running_c && (presc_q == PRESC_W'(TICK_DIV - 1));

  // Run-state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_STOPPED;
    else     state_q <= state_d;
  end

  // Next run state; clear and an accepted load shadow stop/start that cycle.
  always_comb begin
    state_d = state_q;
    if (!bus.clear && !load_fire) begin
      case (state_q)
        ST_STOPPED: if (bus.start && !bus.stop) state_d = ST_RUNNING;
        ST_RUNNING: if (bus.stop)               state_d = ST_STOPPED;
        default:                                state_d = ST_STOPPED;
      endcase
    end
  end

  // Run-state decoded outputs.
  always_comb begin
    running_c    = 1'b0;
    load_ready_c = 1'b0;
    case (state_q)
      ST_STOPPED: load_ready_c = 1'b1;
      ST_RUNNING: running_c    = 1'b1;
      default:    load_ready_c = 1'b1;
    endcase
  end

  bcd_digit_inc u_inc_ones (
    .digit_i      (count_q.ones),
    .carry_in_i   (1'b1),
    .digit_next_o (inc_ones),
    .carry_out_o  (carry_ones)
  );

  bcd_digit_inc u_inc_tens (
    .digit_i      (count_q.tens),
    .carry_in_i   (carry_ones),
    .digit_next_o (inc_tens),
    .carry_out_o  (carry_tens)
  );

  bcd_digit_inc u_inc_hundreds (
    .digit_i      (count_q.hundreds),
    .carry_in_i   (carry_tens),
    .digit_next_o (inc_hundreds),
    .carry_out_o  (carry_hundreds)
  );

  // Prescaler and count update: clear > load > tick.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      presc_d = '0;
      count_d = '0;
    end else begin
      if (running_c) presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      if (load_fire) begin
        count_d.hundreds = sat_digit(bus.load_bcd[3*BCD_DIGIT_W-1 -: BCD_DIGIT_W]);
        count_d.tens     = sat_digit(bus.load_bcd[2*BCD_DIGIT_W-1 -: BCD_DIGIT_W]);
        count_d.ones     = sat_digit(bus.load_bcd[BCD_DIGIT_W-1   -: BCD_DIGIT_W]);
      end else if (tick) begin
        count_d = '{hundreds: inc_hundreds, tens: inc_tens, ones: inc_ones};
        wrap_d  = carry_hundreds;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign show_hundreds = (count_q.hundreds != '0);
  assign show_tens     = (count_q.hundreds != '0) || (count_q.tens != '0);
`else
  assign show_hundreds = 1'b1;
  assign show_tens     = 1'b1;
`endif

  // Scan slot advance; digit and enables are captured together at slot entry.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    slot_d     = slot_q;
    q_d        = q_q;
    en_d       = en_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      slot_d     = slot_e'(slot_q + 2'd1);
      q_d        = '0;
      en_d       = 3'b000;
      case (slot_d)
        SLOT_ONES: begin
          q_d  = count_q.ones;
          en_d = 3'b001;
        end
        SLOT_TENS: begin
          if (show_tens) begin
            q_d  = count_q.tens;
            en_d = 3'b010;
          end
        end
        SLOT_HUNDREDS: begin
          if (show_hundreds) begin
            q_d  = count_q.hundreds;
            en_d = 3'b100;
          end
        end
        default: begin
          q_d  = '0;
          en_d = 3'b000;
        end
      endcase
    end
  end

  // Datapath and scan registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      slot_q     <= SLOT_ONES;
      q_q        <= '0;
      en_q       <= 3'b001;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      slot_q     <= slot_d;
      q_q        <= q_d;
      en_q       <= en_d;
    end
  end

  assign bus.load_ready  = load_ready_c;
  assign bus.running     = running_c;
  assign bus.count_bcd   = count_q;
  assign bus.wrap        = wrap_q;
  assign bus.q           = q_q;
  assign bus.en_ones     = en_q[0];
  assign bus.en_tens     = en_q[1];
  assign bus.en_hundreds = en_q[2];

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: directed scenarios plus random
// commands against a decimal-arithmetic reference model.
module tb_bcd_scan_ctrl;

  localparam int TICK = 4;
  localparam int SCAN = 2;

  logic clk = 1'b0;
  logic rst;

  bcd_scan_ctrl_if bif ();

  bcd_scan_ctrl #(
    .TICK_DIV (TICK),
    .SCAN_DIV (SCAN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state (plain decimal integers).
  int       m_cnt, m_presc, m_cyc, m_q;
  bit       m_run, m_wrap;
  bit [2:0] m_en;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd_to_int_sat(input logic [11:0] b);
    int h, t, o;
    h = int'(b[11:8]); t = int'(b[7:4]); o = int'(b[3:0]);
    if (h > 9) h = 9;
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return h * 100 + t * 10 + o;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_cyc = 0; m_q = 0;
    m_run = 1'b0; m_wrap = 1'b0; m_en = 3'b001;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl,
                            input bit lv, input logic [11:0] lb);
    int  old, h, t, o, slot;
    bit  tk, fire;
    old  = m_cnt;
    tk   = m_run && (m_presc == TICK - 1);
    fire = lv && !m_run;
    m_wrap = 1'b0;
    if (cl) m_cnt = 0;
    else if (fire) m_cnt = bcd_to_int_sat(lb);
    else if (tk) begin
      m_wrap = (m_cnt == 999);
      m_cnt  = (m_cnt + 1) % 1000;
    end
    if (cl) m_presc = 0;
    else if (m_run) m_presc = (m_presc + 1) % TICK;
    if (!cl && !fire) begin
      if (sp) m_run = 1'b0;
      else if (st) m_run = 1'b1;
    end
    m_cyc = (m_cyc + 1) % (4 * SCAN);
    if (m_cyc % SCAN == 0) begin
      slot = m_cyc / SCAN;
      o = old % 10; t = (old / 10) % 10; h = old / 100;
      m_en = 3'b000; m_q = 0;
      if (slot == 0) begin
        m_en = 3'b001; m_q = o;
      end else if (slot == 1) begin
        if (!LZB || h != 0 || t != 0) begin m_en = 3'b010; m_q = t; end
      end else if (slot == 2) begin
        if (!LZB || h != 0) begin m_en = 3'b100; m_q = h; end
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] en;
    en = {bif.en_hundreds, bif.en_tens, bif.en_ones};
    check_eq("count",      32'(bif.count_bcd),  32'(to_bcd(m_cnt)));
    check_eq("running",    32'(bif.running),    32'(m_run));
    check_eq("load_ready", 32'(bif.load_ready), 32'(!m_run));
    check_eq("wrap",       32'(bif.wrap),       32'(m_wrap));
    check_eq("q",          32'(bif.q),          32'(m_q));
    check_eq("en",         32'(en),             32'(m_en));
    check_eq("onehot",     32'($countones(en) <= 1), 32'd1);
  endtask

  // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
  task automatic cycle(input bit r, input bit st, input bit sp, input bit cl,
                       input bit lv, input logic [11:0] lb);
    rst = r; bif.start = st; bif.stop = sp; bif.clear = cl;
    bif.load_valid = lv; bif.load_bcd = lb;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(st, sp, cl, lv, lb);
    #1;
    compare_all();
  endtask

  task automatic idle();           cycle(0, 0, 0, 0, 0, 12'h000); endtask
  task automatic do_start();       cycle(0, 1, 0, 0, 0, 12'h000); endtask
  task automatic do_stop();        cycle(0, 0, 1, 0, 0, 12'h000); endtask
  task automatic do_clear();       cycle(0, 0, 0, 1, 0, 12'h000); endtask
  task automatic do_load(input logic [11:0] v); cycle(0, 0, 0, 0, 1, v); endtask

  task automatic observe_scan(input logic [3:0] exp_o, input logic [3:0] exp_t,
                              input logic [3:0] exp_h, input int n_o, input int n_t,
                              input int n_h);
    int c_o, c_t, c_h, c_b;
    c_o = 0; c_t = 0; c_h = 0; c_b = 0;
    for (int i = 0; i < 4 * SCAN; i++) begin
      idle();
      if (bif.en_ones) begin
        c_o++; check_eq("scan_q_ones", 32'(bif.q), 32'(exp_o));
      end else if (bif.en_tens) begin
        c_t++; check_eq("scan_q_tens", 32'(bif.q), 32'(exp_t));
      end else if (bif.en_hundreds) begin
        c_h++; check_eq("scan_q_hund", 32'(bif.q), 32'(exp_h));
      end else begin
        c_b++; check_eq("scan_q_off", 32'(bif.q), 32'd0);
      end
    end
    check_eq("scan_n_ones", 32'(c_o), 32'(n_o));
    check_eq("scan_n_tens", 32'(c_t), 32'(n_t));
    check_eq("scan_n_hund", 32'(c_h), 32'(n_h));
    check_eq("scan_n_off",  32'(c_b), 32'(4 * SCAN - n_o - n_t - n_h));
  endtask

  initial begin
    rst = 1'b1;
    bif.start = 1'b0; bif.stop = 1'b0; bif.clear = 1'b0;
    bif.load_valid = 1'b0; bif.load_bcd = '0;
    model_reset();

    // Reset state.
    cycle(1, 0, 0, 0, 0, 12'h000);
    check_eq("rst_count", 32'(bif.count_bcd), 32'h000);
    check_eq("rst_run",   32'(bif.running),   32'd0);
    check_eq("rst_ready", 32'(bif.load_ready), 32'd1);
    check_eq("rst_en1",   32'(bif.en_ones),   32'd1);
    check_eq("rst_q",     32'(bif.q),         32'd0);

    // Run 40 cycles: increments every TICK cycles, 010 at the 40th.
    do_start();
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (i == 39) check_eq("run39", 32'(bif.count_bcd), 32'h009);
      if (i == 40) check_eq("run40", 32'(bif.count_bcd), 32'h010);
    end

    // 998 -> 999 -> 000 with a single wrap pulse.
    do_stop(); do_clear(); do_load(12'h998);
    check_eq("load998", 32'(bif.count_bcd), 32'h998);
    do_start();
    for (int i = 1; i <= 9; i++) begin
      idle();
      if (i == 4) check_eq("at999", 32'(bif.count_bcd), 32'h999);
      if (i == 8) begin
        check_eq("at000", 32'(bif.count_bcd), 32'h000);
        check_eq("wrap_hi", 32'(bif.wrap), 32'd1);
      end
      if (i == 9) check_eq("wrap_lo", 32'(bif.wrap), 32'd0);
    end

    // Saturating load while stopped; load ignored while running.
    do_stop(); do_load(12'hA3F);
    check_eq("load_sat", 32'(bif.count_bcd), 32'h939);
    do_start();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 12'h123);
      check_eq("ld_ready_run", 32'(bif.load_ready), 32'd0);
      check_eq("ld_ignored", 32'(bif.count_bcd == 12'h123), 32'd0);
    end

    // Clear coincident with a tick at 047; then start+stop together.
    do_stop(); do_clear(); do_load(12'h046); do_start();
    for (int i = 0; i < 4; i++) idle();
    check_eq("at047", 32'(bif.count_bcd), 32'h047);
    for (int i = 0; i < 3; i++) idle();
    do_clear();
    check_eq("clr_tick_cnt",  32'(bif.count_bcd), 32'h000);
    check_eq("clr_tick_wrap", 32'(bif.wrap), 32'd0);
    check_eq("clr_keeps_run", 32'(bif.running), 32'd1);
    do_stop();
    cycle(0, 1, 1, 0, 0, 12'h000);
    check_eq("stop_wins", 32'(bif.running), 32'd0);

    // Frozen 305: full scan rotation.
    do_load(12'h305);
    for (int i = 0; i < 4 * SCAN; i++) idle();
    observe_scan(4'd5, 4'd0, 4'd3, SCAN, SCAN, SCAN);

`ifdef LEADING_ZERO_BLANK_EN
    // Leading zeros suppressed: 007 shows only the ones digit.
    do_load(12'h007);
    for (int i = 0; i < 4 * SCAN; i++) idle();
    observe_scan(4'd7, 4'd0, 4'd0, SCAN, 0, 0);
`endif

    // Random command mix against the model, including mid-run resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(99) == 0),
            ($urandom_range(7) == 0),
            ($urandom_range(11) == 0),
            ($urandom_range(29) == 0),
            ($urandom_range(5) == 0),
            12'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
